// File: rtl/alu_pipe.sv
// Single-issue ALU with a registered result stage and valid/ready handshakes.
// Non-divide ops finish in one cycle; DIVU/REMU run a restoring divider, one bit per cycle.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic {IDLE, DIV} state_t;
    state_t state;

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             is_rem;
    logic [SHW-1:0]   cnt;

    logic             accept, is_div;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] f_res;
    logic             f_c, f_v, f_ill;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] nrem, nquo;

    assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_div   = (alu_op == 4'd10 || alu_op == 4'd11) && (b != '0);

    always_comb begin
        sum   = '0;
        f_res = '0;
        f_c   = 1'b0;
        f_v   = 1'b0;
        f_ill = 1'b0;
        case (alu_op)
            4'd0: begin
                sum   = {1'b0, a} + {1'b0, b};
                f_res = sum[WIDTH-1:0];
                f_c   = sum[WIDTH];
                f_v   = (a[WIDTH-1] == b[WIDTH-1]) && (f_res[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                f_res = a - b;
                f_c   = (a >= b);
                f_v   = (a[WIDTH-1] != b[WIDTH-1]) && (f_res[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2:  f_res = a & b;
            4'd3:  f_res = a | b;
            4'd4:  f_res = a ^ b;
            4'd5:  f_res = a << b[SHW-1:0];
            4'd6:  f_res = a >> b[SHW-1:0];
            4'd7:  f_res = $signed(a) >>> b[SHW-1:0];
            4'd8:  f_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd9:  f_res = {{(WIDTH-1){1'b0}}, (a < b)};
            // Only reached as a single-cycle op when b == 0.
            4'd10: f_res = '1;
            4'd11: f_res = a;
            default: f_ill = 1'b1;
        endcase
    end

    // Restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            nrem = trial[WIDTH-1:0];
            nquo = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            nrem = shifted[WIDTH-1:0];
            nquo = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            is_rem    <= 1'b0;
            cnt       <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_div) begin
                        state  <= DIV;
                        rem_q  <= '0;
                        quo_q  <= a;
                        dvs_q  <= b;
                        is_rem <= alu_op[0];
                        cnt    <= '0;
                    end else if (accept) begin
                        result    <= f_res;
                        zero      <= (f_res == '0);
                        carry     <= f_c;
                        overflow  <= f_v;
                        illegal   <= f_ill;
                        out_valid <= 1'b1;
                    end
                end
                DIV: begin
                    rem_q <= nrem;
                    quo_q <= nquo;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= IDLE;
                        result    <= is_rem ? nrem : nquo;
                        zero      <= ((is_rem ? nrem : nquo) == '0);
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner cases, an 8-bit build, and random traffic
// checked every cycle against a queue-based behavioural model.
module tb_alu_pipe;
    logic        clk = 0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  alu_op;
    logic        zero, carry, overflow, illegal;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, result8;
    logic [3:0]  alu_op8;
    logic        zero8, carry8, overflow8, illegal8;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .overflow(overflow), .illegal(illegal));

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .alu_op(alu_op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .zero(zero8), .carry(carry8), .overflow(overflow8), .illegal(illegal8));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z, c, v, ill;
        int          vcyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0, checks = 0;
    int   busy_until = 0;
    bit   took = 0;
    int   t_acc, lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb);
        exp_t   r;
        longint ls;
        logic [32:0] s;
        int     sh;
        sh    = int'(xb[4:0]);
        r.res = '0; r.c = 0; r.v = 0; r.ill = 0; r.vcyc = 0;
        case (op)
            0: begin
                s = {1'b0, xa} + {1'b0, xb};
                r.res = s[31:0]; r.c = s[32];
                ls = longint'($signed(xa)) + longint'($signed(xb));
                r.v = (ls != longint'($signed(r.res)));
            end
            1: begin
                r.res = xa - xb; r.c = (xa >= xb);
                ls = longint'($signed(xa)) - longint'($signed(xb));
                r.v = (ls != longint'($signed(r.res)));
            end
            2: r.res = xa & xb;
            3: r.res = xa | xb;
            4: r.res = xa ^ xb;
            5: r.res = xa << sh;
            6: r.res = xa >> sh;
            7: r.res = (xa >> sh) | (xa[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            8: r.res = (longint'($signed(xa)) < longint'($signed(xb))) ? 32'd1 : 32'd0;
            9: r.res = (longint'(xa) < longint'(xb)) ? 32'd1 : 32'd0;
            10: r.res = (xb == 0) ? 32'hFFFF_FFFF : xa / xb;
            11: r.res = (xb == 0) ? xa : xa % xb;
            default: r.ill = 1;
        endcase
        r.z = (r.res == 0);
        return r;
    endfunction

    function automatic int latency(input logic [3:0] op, input logic [31:0] xb);
        return ((op == 10 || op == 11) && xb != 0) ? 33 : 1;
    endfunction

    // Compare process: every cycle, DUT handshake and outputs vs the model queue.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_ov;
        if (reset) begin
            chk("in_ready_in_reset", in_ready, 0);
            q.delete();
            busy_until = cyc + 1;
            took = 0;
        end else begin
            exp_ov = 0;
            if (q.size() > 0) exp_ov = (cyc >= q[0].vcyc);
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, (cyc >= busy_until) && (!exp_ov || out_ready));
            if (exp_ov && out_valid) begin
                e = q[0];
                chk("result", result, e.res);
                chk("flags_zcvi", {zero, carry, overflow, illegal}, {e.z, e.c, e.v, e.ill});
                if (out_ready) void'(q.pop_front());
            end
            took = in_valid && in_ready;
            if (took) begin
                e = model(alu_op, a, b);
                e.vcyc = cyc + latency(alu_op, b);
                busy_until = e.vcyc;
                q.push_back(e);
            end
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb, input bit ordy);
        int n;
        @(posedge clk); #1;
        in_valid = 1; alu_op = op; a = xa; b = xb; out_ready = ordy;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) chk("accept_timeout", 0, 1);
        t_acc = cyc;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        if (!out_valid) chk("result_timeout", 0, 1);
        lat = cyc - t_acc;
    endtask

    task automatic do_op8(input logic [3:0] op, input logic [7:0] xa, input logic [7:0] xb);
        int n;
        @(posedge clk); #1;
        in_valid8 = 1; alu_op8 = op; a8 = xa; b8 = xb; out_ready8 = 1;
        n = 0;
        @(negedge clk);
        while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
        if (!in_ready8) chk("accept8_timeout", 0, 1);
        t_acc = cyc;
        @(posedge clk); #1;
        in_valid8 = 0;
        n = 0;
        @(negedge clk);
        while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
        if (!out_valid8) chk("result8_timeout", 0, 1);
        lat = cyc - t_acc;
    endtask

    initial begin
        exp_t m;
        int   cnt;
        reset = 1; in_valid = 0; a = 0; b = 0; alu_op = 0; out_ready = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; alu_op8 = 0; out_ready8 = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result_flags", {result, zero, carry, overflow, illegal}, 0);
        chk("in_ready_after_reset", in_ready, 1);

        // Pin the model itself with hand-computed values.
        m = model(0, 32'hFFFF_FFFF, 32'd1);
        chk("model_add_wrap", {m.res, m.z, m.c, m.v}, {32'h0, 1'b1, 1'b1, 1'b0});
        m = model(7, 32'h8000_0000, 32'h24);
        chk("model_sra", m.res, 32'hF800_0000);
        m = model(11, 32'd100, 32'd7);
        chk("model_remu", m.res, 32'd2);

        do_op(0, 32'hFFFF_FFFF, 32'd1, 1);
        chk("add_wrap_lat", lat, 1);
        chk("add_wrap", {result, zero, carry, overflow}, {32'h0, 1'b1, 1'b1, 1'b0});
        do_op(0, 32'h7FFF_FFFF, 32'd1, 1);
        chk("add_ovf", {result, carry, overflow}, {32'h8000_0000, 1'b0, 1'b1});
        do_op(1, 32'd3, 32'd5, 1);
        chk("sub_neg", {result, carry}, {32'hFFFF_FFFE, 1'b0});
        do_op(10, 32'd100, 32'd7, 1);
        chk("divu_lat", lat, 33);
        chk("divu", result, 32'd14);
        do_op(11, 32'd100, 32'd7, 1);
        chk("remu_lat", lat, 33);
        chk("remu", result, 32'd2);
        do_op(10, 32'd55, 32'd0, 1);
        chk("divu_by0", {result, lat[7:0]}, {32'hFFFF_FFFF, 8'd1});
        do_op(11, 32'd9, 32'd0, 1);
        chk("remu_by0", result, 32'd9);
        do_op(13, 32'd1, 32'd2, 1);
        chk("illegal", {result, illegal, zero}, {32'h0, 1'b1, 1'b1});

        // Hold a SRA result, then release it together with a new request.
        do_op(7, 32'h8000_0000, 32'h24, 0);
        for (int i = 0; i < 3; i++) begin
            chk("sra_hold", result, 32'hF800_0000);
            chk("sra_hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1; in_valid = 1; alu_op = 0; a = 32'd1; b = 32'd2;
        @(negedge clk);
        chk("b2b_in_ready", in_ready, 1);
        chk("b2b_first", result, 32'hF800_0000);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("b2b_second", {out_valid, result}, {1'b1, 32'd3});

        // Reset in the middle of a divide.
        @(posedge clk); #1;
        in_valid = 1; alu_op = 10; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        chk("div_abort_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) cnt++;
            @(negedge clk);
        end
        chk("abort_no_result", cnt, 0);

        // 8-bit build.
        do_op8(0, 8'hFF, 8'h01);
        chk("w8_add_lat", lat, 1);
        chk("w8_add", {result8, zero8, carry8, overflow8}, {8'h00, 1'b1, 1'b1, 1'b0});
        do_op8(10, 8'd100, 8'd7);
        chk("w8_divu_lat", lat, 9);
        chk("w8_divu", result8, 8'd14);
        do_op8(11, 8'd100, 8'd7);
        chk("w8_remu", {result8, lat[7:0]}, {8'd2, 8'd9});

        // Random traffic with random back-pressure and occasional resets.
        @(posedge clk); #1;
        in_valid = 0;
        for (int n = 0; n < 6000; n++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 399) == 0);
            if (took || !in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1;
                    alu_op = 4'($urandom_range(0, 15));
                    a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                    case ($urandom_range(0, 7))
                        0: b = 32'd0;
                        1: b = $urandom_range(0, 40);
                        2: b = 32'hFFFF_FFFF;
                        default: b = $urandom;
                    endcase
                end else begin
                    in_valid = 0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        reset = 0; in_valid = 0; out_ready = 1;
        cnt = 0;
        while (q.size() > 0 && cnt < 200) begin @(negedge clk); cnt++; end
        chk("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits; SHALL be a power of two, 8 to 64.
REQ-002 Derived localparam SHW = log2(WIDTH) SHALL set the shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 alu_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 DIVU, 11 REMU, 12-15 illegal.
REQ-009 out_valid  output  1  result register holds an undelivered result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 result  output  WIDTH  registered result.
REQ-012 zero, carry, overflow, illegal  output  1 each  flags registered with result.

Function
REQ-013 A request SHALL be accepted on any cycle where in_valid and in_ready are both high; a, b and alu_op SHALL be captured on that edge.
REQ-014 in_ready SHALL be high only when the FSM is in IDLE and either out_valid is low or out_ready is high.
REQ-015 The FSM SHALL have exactly two states: IDLE, and DIV (iterative divide in progress).
REQ-016 Opcodes 0-9, 12-15, and divides with b == 0, SHALL take one cycle: out_valid rises on the edge after acceptance; FSM stays in IDLE.
REQ-017 DIVU and REMU with b != 0 SHALL move IDLE->DIV and run restoring radix-2 division, one quotient bit per cycle, for WIDTH cycles.
REQ-018 On the last DIV cycle, the result register SHALL load and the FSM return to IDLE; out_valid SHALL rise exactly WIDTH+1 edges after acceptance.
REQ-019 DIVU SHALL return the quotient; REMU SHALL return the remainder.
REQ-020 On divide by zero, DIVU SHALL return all ones and REMU SHALL return a.
REQ-021 Shift operations SHALL use b[SHW-1:0] only; SRA SHALL replicate a[WIDTH-1].
REQ-022 SLT (signed) and SLTU (unsigned) SHALL return 1 or 0, zero-extended to WIDTH.
REQ-023 ADD and SUB SHALL wrap modulo 2^WIDTH.
REQ-024 ADD carry SHALL be the carry-out of bit WIDTH-1; SUB carry SHALL be 1 when a >= b unsigned.
REQ-025 overflow SHALL be set on signed overflow for ADD and SUB.
REQ-026 carry and overflow SHALL be 0 for all other opcodes.
REQ-027 zero SHALL be 1 when the registered result equals 0.
REQ-028 Illegal opcodes SHALL return result 0 with illegal=1, zero=1; illegal SHALL be 0 for all legal opcodes.
REQ-029 result and all flags SHALL be held stable while out_valid=1 and out_ready=0.
REQ-030 out_valid SHALL clear on the edge where out_ready=1, unless a new result loads on that same edge, in which case out_valid stays 1 with the new data.
REQ-031 Results SHALL be delivered in acceptance order; no request SHALL be dropped or duplicated.

Reset
REQ-032 While reset=1 on a clock edge, the FSM SHALL go to IDLE and out_valid, result, zero, carry, overflow and illegal SHALL all clear to 0.
REQ-033 in_ready SHALL be 0 during any cycle where reset is sampled high, and 1 on the first cycle after reset deasserts.
REQ-034 Reset during DIV SHALL abort the divide with no result delivered; any undelivered result SHALL be discarded.

Verification
REQ-035 WIDTH=32: ADD a=0xFFFFFFFF, b=1, out_ready=1 -> next cycle out_valid=1, result=0, zero=1, carry=1, overflow=0.
REQ-036 WIDTH=32: ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, carry=0.
REQ-037 WIDTH=32: SUB a=3, b=5 -> result=0xFFFFFFFE, carry=0.
REQ-038 WIDTH=32: DIVU a=100, b=7 accepted at cycle t -> out_valid at t+33, result=14; REMU with the same operands -> result=2; in_ready=0 for cycles t+1..t+32.
REQ-039 WIDTH=32: DIVU b=0 -> 0xFFFFFFFF in one cycle; REMU a=9, b=0 -> 9.
REQ-040 WIDTH=32: hold out_ready=0 after a SRA with a=0x80000000, b=0x24 (shift 4) -> result=0xF8000000 held and in_ready=0; raising out_ready together with a new in_valid gives back-to-back delivery.
REQ-041 WIDTH=32: opcode 13 -> result=0, illegal=1.
REQ-042 WIDTH=32: reset at cycle 10 of a DIVU -> no out_valid is produced, and in_ready=1 one cycle after reset deasserts.
REQ-043 The WIDTH=8 build SHALL repeat REQ-035 and REQ-038 with 8-bit values; the divide latency SHALL be 9 edges.
